mdc_b: RTL

MDC_B -- requirements
Module: mdc_b

---
 rtl/mdc_pkg.sv | 15 +
 rtl/mdc_step.sv | 31 +++
 rtl/mdc_b.sv | 88 ++++++++
 3 files changed

// File: rtl/mdc_pkg.sv
// rtl/mdc_pkg.sv - shared GCD datapath width and FSM state encoding
// Purpose: constants and types shared by mdc_b and mdc_step.
//   WIDTH   : operand/result/counter width
//   state_e : IDLE / RUN / DONE controller states
package mdc_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdc_step.sv
// rtl/mdc_step.sv - one subtractive-GCD step, purely combinational
// Purpose: compare the two operands and produce the next operand pair.
// Ports:
//   a_i, b_i         : current operands
//   next_a_o/next_b_o: operands after subtracting the smaller from the larger
//   eq_o             : a_i == b_i
//   a_zero_o/b_zero_o: operand is zero
module mdc_step
  import mdc_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] next_a_o,
  output logic [WIDTH-1:0] next_b_o,
  output logic             eq_o,
  output logic             a_zero_o,
  output logic             b_zero_o
);

  logic a_gt_b;

  assign a_gt_b   = (a_i > b_i);
  assign eq_o     = (a_i == b_i);
  assign a_zero_o = (a_i == '0);
  assign b_zero_o = (b_i == '0);

  // Only the larger operand shrinks, so the difference can never wrap.
  assign next_a_o = a_gt_b ? (a_i - b_i) : a_i;
  assign next_b_o = a_gt_b ? b_i : (b_i - a_i);

endmodule

// File: rtl/mdc_b.sv
// rtl/mdc_b.sv - iterative subtractive GCD engine with IDLE/RUN/DONE control
// Purpose: loads two unsigned operands and repeatedly subtracts the smaller
//          from the larger until one is zero or both are equal.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, wins over ld
//   ld    : load i_a/i_b and (re)start; restarts even while running
//   i_a/b : operands, sampled only when ld=1
//   res   : GCD result, valid while done=1
//   done  : result-valid level
//   busy  : computation in progress
//   iter  : subtraction steps taken, wraps modulo 2^WIDTH
module mdc_b
  import mdc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] iter
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] iter_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             eq;
  logic             a_zero;
  logic             b_zero;

  mdc_step u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .next_a_o (next_a),
    .next_b_o (next_b),
    .eq_o     (eq),
    .a_zero_o (a_zero),
    .b_zero_o (b_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ld) begin
      // Load behaves identically in every state; a run in flight is dropped.
      state_q <= RUN;
      a_q     <= i_a;
      b_q     <= i_b;
      iter_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else if (state_q == RUN) begin
      if (a_zero || b_zero || eq) begin
        // Zero operand yields the other one; equal operands yield either.
        res_q   <= a_zero ? b_q : a_q;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= DONE;
      end else begin
        a_q    <= next_a;
        b_q    <= next_b;
        iter_q <= iter_q + WIDTH'(1);
      end
    end
  end

  assign res  = res_q;
  assign done = done_q;
  assign busy = busy_q;
  assign iter = iter_q;

endmodule
